irq_seq: RTL and testbench

IRQ_SEQ -- requirements
Module: irq_seq

---
 rtl/irq_seq_if.sv | 36 +++
 rtl/irq_seq.sv | 182 ++++++++++++++++++
 tb/tb_irq_seq.sv | 195 +++++++++++++++++++
 3 files changed

// File: rtl/irq_seq_if.sv
// Trap/mret sequencer bus: EX-stage event inputs, CSR read values, CSR write port, pipeline control.
// Latency: n/a (signal bundle only).
// Backpressure: n/a; div_busy_i is carried here as the only hold-off input to the sequencer.
interface irq_seq_if;
   logic        inst_valid_i;
   logic [31:0] inst_addr_i;
   logic        ecall_i;
   logic        ebreak_i;
   logic        mret_i;
   logic        irq_i;
   logic        div_busy_i;
   logic [31:0] csr_mtvec_i;
   logic [31:0] csr_mepc_i;
   logic [31:0] csr_mstatus_i;
   logic        csr_we_o;
   logic [11:0] csr_waddr_o;
   logic [31:0] csr_wdata_o;
   logic        stallreq_o;
   logic [2:0]  flushreq_o;
   logic        jump_req_o;
   logic [31:0] jump_addr_o;

   // Sequencer side: consumes EX/CSR state, drives CSR writes and pipeline control.
   modport master (
      input  inst_valid_i, inst_addr_i, ecall_i, ebreak_i, mret_i, irq_i, div_busy_i,
      input  csr_mtvec_i, csr_mepc_i, csr_mstatus_i,
      output csr_we_o, csr_waddr_o, csr_wdata_o, stallreq_o, flushreq_o, jump_req_o, jump_addr_o
   );

   // Pipeline/CSR-file side.
   modport slave (
      output inst_valid_i, inst_addr_i, ecall_i, ebreak_i, mret_i, irq_i, div_busy_i,
      output csr_mtvec_i, csr_mepc_i, csr_mstatus_i,
      input  csr_we_o, csr_waddr_o, csr_wdata_o, stallreq_o, flushreq_o, jump_req_o, jump_addr_o
   );
endinterface

// File: rtl/irq_seq.sv
// Interrupt/exception/mret sequencer: writes mepc, mcause, mstatus then redirects the fetch; VECTORED_MTVEC_EN enables vectored irq targets.
// Latency: trap redirect 4 cycles after detection (plus any div_busy_i wait), mret redirect 2 cycles after.
// Backpressure: trap entry holds in WAIT while div_busy_i is high; stallreq_o freezes the pipeline for the whole sequence.
module irq_seq (
   input  logic     clk,
   input  logic     rst_n,
   irq_seq_if.master bus
);

   typedef enum logic [2:0] {
      ST_IDLE, ST_WAIT, ST_MEPC, ST_MCAUSE, ST_MSTATUS, ST_MRET, ST_JUMP
   } state_t;

   localparam logic [11:0] ADDR_MEPC    = 12'h341;
   localparam logic [11:0] ADDR_MCAUSE  = 12'h342;
   localparam logic [11:0] ADDR_MSTATUS = 12'h300;

   localparam logic [31:0] CAUSE_IRQ    = 32'h8000_000B;
   localparam logic [31:0] CAUSE_ECALL  = 32'h0000_000B;
   localparam logic [31:0] CAUSE_EBREAK = 32'h0000_0003;

   // Event kind is stored directly as the flush mask it will produce in JUMP.
   localparam logic [2:0] KIND_EXC  = 3'b001;
   localparam logic [2:0] KIND_IRQ  = 3'b010;
   localparam logic [2:0] KIND_MRET = 3'b100;

   state_t      state_q, state_d;
   logic [2:0]  kind_q;
   logic [31:0] cause_q;
   logic [31:0] pc_q;

   logic        irq_ev, ecall_ev, ebreak_ev, mret_ev, trap_ev, detect;
   logic [2:0]  det_kind;
   logic [31:0] det_cause;
   logic [31:0] trap_target;

   logic        csr_we;
   logic [11:0] csr_waddr;
   logic [31:0] csr_wdata;
   logic        stallreq;
   logic [2:0]  flushreq;
   logic        jump_req;
   logic [31:0] jump_addr;

   // Event qualification and priority: irq > ecall > ebreak > mret.
   always_comb begin
      irq_ev    = bus.irq_i & bus.csr_mstatus_i[3] & bus.inst_valid_i;
      ecall_ev  = bus.ecall_i  & bus.inst_valid_i;
      ebreak_ev = bus.ebreak_i & bus.inst_valid_i;
      trap_ev   = irq_ev | ecall_ev | ebreak_ev;
      mret_ev   = bus.mret_i & bus.inst_valid_i & ~trap_ev;
      // Gated by rst_n so nothing is requested while reset is held.
      detect    = rst_n & (state_q == ST_IDLE) & (trap_ev | mret_ev);
      det_kind  = KIND_MRET;
      det_cause = 32'h0;
      if (irq_ev) begin
         det_kind  = KIND_IRQ;
         det_cause = CAUSE_IRQ;
      end else if (ecall_ev) begin
         det_kind  = KIND_EXC;
         det_cause = CAUSE_ECALL;
      end else if (ebreak_ev) begin
         det_kind  = KIND_EXC;
         det_cause = CAUSE_EBREAK;
      end
   end

   // Trap vector: direct base, optionally offset by cause 11 for vectored irqs.
`ifdef VECTORED_MTVEC_EN
   always_comb begin
      trap_target = {bus.csr_mtvec_i[31:2], 2'b00};
      if (kind_q == KIND_IRQ && bus.csr_mtvec_i[1:0] == 2'b01)
         trap_target = {bus.csr_mtvec_i[31:2], 2'b00} + 32'h0000_002C;
   end
`else
   logic unused_mtvec_mode;
   assign unused_mtvec_mode = ^bus.csr_mtvec_i[1:0];
   always_comb begin
      trap_target = {bus.csr_mtvec_i[31:2], 2'b00};
   end
`endif

   // State register.
   always_ff @(posedge clk) begin
      if (!rst_n)
         state_q <= ST_IDLE;
      else
         state_q <= state_d;
   end

   // Capture kind, cause and PC once per sequence, on the detection cycle only.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         kind_q  <= 3'b000;
         cause_q <= 32'h0;
         pc_q    <= 32'h0;
      end else if (detect) begin
         kind_q  <= det_kind;
         cause_q <= det_cause;
         pc_q    <= bus.inst_addr_i;
      end
   end

   // Next-state logic.
   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE: begin
            if (detect) begin
               if (!trap_ev)             state_d = ST_MRET;
               else if (bus.div_busy_i)  state_d = ST_WAIT;
               else                      state_d = ST_MEPC;
            end
         end
         ST_WAIT:    if (!bus.div_busy_i) state_d = ST_MEPC;
         ST_MEPC:    state_d = ST_MCAUSE;
         ST_MCAUSE:  state_d = ST_MSTATUS;
         ST_MSTATUS: state_d = ST_JUMP;
         ST_MRET:    state_d = ST_JUMP;
         ST_JUMP:    state_d = ST_IDLE;
         default:    state_d = ST_IDLE;
      endcase
   end

   // Output decode: CSR write port, stall, flush and redirect.
   always_comb begin
      csr_we    = 1'b0;
      csr_waddr = 12'h0;
      csr_wdata = 32'h0;
      stallreq  = 1'b0;
      flushreq  = 3'b000;
      jump_req  = 1'b0;
      jump_addr = 32'h0;
      case (state_q)
         ST_IDLE: stallreq = detect;
         ST_WAIT: stallreq = 1'b1;
         ST_MEPC: begin
            stallreq  = 1'b1;
            csr_we    = 1'b1;
            csr_waddr = ADDR_MEPC;
            csr_wdata = pc_q;
         end
         ST_MCAUSE: begin
            stallreq  = 1'b1;
            csr_we    = 1'b1;
            csr_waddr = ADDR_MCAUSE;
            csr_wdata = cause_q;
         end
         ST_MSTATUS: begin
            stallreq     = 1'b1;
            csr_we       = 1'b1;
            csr_waddr    = ADDR_MSTATUS;
            csr_wdata    = bus.csr_mstatus_i;
            csr_wdata[7] = bus.csr_mstatus_i[3];
            csr_wdata[3] = 1'b0;
         end
         ST_MRET: begin
            stallreq     = 1'b1;
            csr_we       = 1'b1;
            csr_waddr    = ADDR_MSTATUS;
            csr_wdata    = bus.csr_mstatus_i;
            csr_wdata[3] = bus.csr_mstatus_i[7];
            csr_wdata[7] = 1'b1;
         end
         ST_JUMP: begin
            jump_req  = 1'b1;
            flushreq  = kind_q;
            jump_addr = (kind_q == KIND_MRET) ? bus.csr_mepc_i : trap_target;
         end
         default: ;
      endcase
   end

   assign bus.csr_we_o    = csr_we;
   assign bus.csr_waddr_o = csr_waddr;
   assign bus.csr_wdata_o = csr_wdata;
   assign bus.stallreq_o  = stallreq;
   assign bus.flushreq_o  = flushreq;
   assign bus.jump_req_o  = jump_req;
   assign bus.jump_addr_o = jump_addr;

endmodule

// File: tb/tb_irq_seq.sv
// Directed bench for irq_seq: trap, wait, priority, mret, vectoring and reset-abort scenarios.
// Latency: outputs are sampled 1 time unit after each rising edge.
// Backpressure: div_busy_i is driven directly to exercise the WAIT hold.
module tb_irq_seq;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int   n_chk = 0;
   int   n_bad = 0;

   irq_seq_if bus ();

   irq_seq dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      if (obs !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h, want %h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic clear_events();
      bus.inst_valid_i = 1'b0;
      bus.ecall_i      = 1'b0;
      bus.ebreak_i     = 1'b0;
      bus.mret_i       = 1'b0;
      bus.irq_i        = 1'b0;
      bus.div_busy_i   = 1'b0;
   endtask

   task automatic check_quiet(input string tag);
      check_eq({tag, "_ctl"}, {27'h0, bus.csr_we_o, bus.stallreq_o, bus.flushreq_o == 3'b000 ? 1'b0 : 1'b1,
                              bus.jump_req_o, 1'b0}, 32'h0);
      check_eq({tag, "_dat"}, bus.csr_wdata_o | bus.jump_addr_o | {20'h0, bus.csr_waddr_o}, 32'h0);
   endtask

   // Called with the state about to enter MEPC on the next edge.
   // Event inputs are scrambled mid-sequence to show latched values are kept.
   task automatic run_trap(input string tag, input logic [31:0] exp_pc, input logic [31:0] exp_cause,
                           input logic [31:0] exp_ms, input logic [31:0] exp_tgt, input logic [2:0] exp_flush);
      step();
      check_eq({tag, "_mepc_a"}, {19'h0, bus.csr_we_o, bus.csr_waddr_o}, {19'h0, 1'b1, 12'h341});
      check_eq({tag, "_mepc_d"}, bus.csr_wdata_o, exp_pc);
      check_eq({tag, "_mepc_stall"}, {31'h0, bus.stallreq_o}, 32'h1);
      bus.inst_valid_i = 1'b1;
      bus.ecall_i      = 1'b1;
      bus.ebreak_i     = 1'b1;
      bus.irq_i        = ~bus.irq_i;
      bus.inst_addr_i  = 32'hDEAD_0000;
      step();
      check_eq({tag, "_mcause_a"}, {19'h0, bus.csr_we_o, bus.csr_waddr_o}, {19'h0, 1'b1, 12'h342});
      check_eq({tag, "_mcause_d"}, bus.csr_wdata_o, exp_cause);
      step();
      check_eq({tag, "_mstatus_a"}, {19'h0, bus.csr_we_o, bus.csr_waddr_o}, {19'h0, 1'b1, 12'h300});
      check_eq({tag, "_mstatus_d"}, bus.csr_wdata_o, exp_ms);
      clear_events();
      step();
      check_eq({tag, "_jump_ctl"}, {27'h0, bus.jump_req_o, bus.flushreq_o, bus.stallreq_o},
               {27'h0, 1'b1, exp_flush, 1'b0});
      check_eq({tag, "_jump_addr"}, bus.jump_addr_o, exp_tgt);
      check_eq({tag, "_jump_we"}, {31'h0, bus.csr_we_o}, 32'h0);
      step();
      check_quiet({tag, "_idle"});
   endtask

   // Presents one event at the current PC and checks the combinational stall on detection.
   task automatic launch(input string tag, input logic [31:0] pc, input logic irq, input logic ecall,
                         input logic ebreak, input logic [31:0] mstatus, input logic [31:0] mtvec);
      bus.csr_mstatus_i = mstatus;
      bus.csr_mtvec_i   = mtvec;
      bus.inst_addr_i   = pc;
      bus.inst_valid_i  = 1'b1;
      bus.irq_i         = irq;
      bus.ecall_i       = ecall;
      bus.ebreak_i      = ebreak;
      #1;
      check_eq({tag, "_det_stall"}, {31'h0, bus.stallreq_o}, 32'h1);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout, want finish");
      $fatal(1, "watchdog");
   end

   initial begin
      clear_events();
      bus.inst_addr_i   = 32'h0;
      bus.csr_mtvec_i   = 32'h0;
      bus.csr_mepc_i    = 32'h0;
      bus.csr_mstatus_i = 32'h0;

      // Reset state.
      step();
      step();
      check_quiet("reset");
      rst_n = 1'b1;
      step();
      check_quiet("post_reset");

      // Basic irq trap: mepc 0x40, mcause irq, mstatus 0x8 -> 0x80, jump 0x100 flush irq.
      launch("irq", 32'h40, 1'b1, 1'b0, 1'b0, 32'h8, 32'h100);
      run_trap("irq", 32'h40, 32'h8000_000B, 32'h80, 32'h100, 3'b010);

      // ecall while a divide is busy for three cycles.
      bus.div_busy_i = 1'b1;
      launch("busy", 32'h80, 1'b0, 1'b1, 1'b0, 32'h8, 32'h100);
      for (int i = 0; i < 3; i++) begin
         step();
         check_eq($sformatf("busy_wait%0d", i), {30'h0, bus.stallreq_o, bus.csr_we_o}, 32'h2);
         if (i == 2) bus.div_busy_i = 1'b0;
      end
      run_trap("busy", 32'h80, 32'h0000_000B, 32'h80, 32'h100, 3'b001);

      // irq and ecall together: MIE=1 takes irq, MIE=0 takes ecall.
      launch("prio_mie1", 32'h200, 1'b1, 1'b1, 1'b0, 32'h8, 32'h100);
      run_trap("prio_mie1", 32'h200, 32'h8000_000B, 32'h80, 32'h100, 3'b010);
      launch("prio_mie0", 32'h204, 1'b1, 1'b1, 1'b0, 32'h0, 32'h100);
      run_trap("prio_mie0", 32'h204, 32'h0000_000B, 32'h0, 32'h100, 3'b001);

      // ebreak with unrelated mstatus bits preserved: 0x1808 -> 0x1880.
      launch("ebreak", 32'h300, 1'b0, 1'b0, 1'b1, 32'h1808, 32'h400);
      run_trap("ebreak", 32'h300, 32'h0000_0003, 32'h1880, 32'h400, 3'b001);

      // Vectored mtvec: irq offsets only when the build enables it; exceptions always use base.
      launch("vec_irq", 32'h60, 1'b1, 1'b0, 1'b0, 32'h8, 32'h101);
`ifdef VECTORED_MTVEC_EN
      run_trap("vec_irq", 32'h60, 32'h8000_000B, 32'h80, 32'h12C, 3'b010);
`else
      run_trap("vec_irq", 32'h60, 32'h8000_000B, 32'h80, 32'h100, 3'b010);
`endif
      launch("vec_exc", 32'h64, 1'b0, 1'b1, 1'b0, 32'h8, 32'h101);
      run_trap("vec_exc", 32'h64, 32'h0000_000B, 32'h80, 32'h100, 3'b001);

      // mret: mstatus 0x80 -> 0x88, jump to mepc 0x44 two cycles after detection.
      bus.csr_mstatus_i = 32'h80;
      bus.csr_mepc_i    = 32'h44;
      bus.inst_valid_i  = 1'b1;
      bus.mret_i        = 1'b1;
      #1;
      check_eq("mret_det_stall", {31'h0, bus.stallreq_o}, 32'h1);
      step();
      check_eq("mret_ms_a", {19'h0, bus.csr_we_o, bus.csr_waddr_o}, {19'h0, 1'b1, 12'h300});
      check_eq("mret_ms_d", bus.csr_wdata_o, 32'h88);
      check_eq("mret_stall", {31'h0, bus.stallreq_o}, 32'h1);
      clear_events();
      step();
      check_eq("mret_jump_ctl", {27'h0, bus.jump_req_o, bus.flushreq_o, bus.stallreq_o}, {27'h0, 1'b1, 3'b100, 1'b0});
      check_eq("mret_jump_addr", bus.jump_addr_o, 32'h44);
      step();
      check_quiet("mret_idle");

      // Unqualified events (no inst_valid_i) are not taken.
      bus.csr_mstatus_i = 32'h8;
      bus.irq_i   = 1'b1;
      bus.ecall_i = 1'b1;
      bus.mret_i  = 1'b1;
      #1;
      check_eq("novalid_stall", {31'h0, bus.stallreq_o}, 32'h0);
      step();
      check_quiet("novalid_next");
      clear_events();

      // Reset in MCAUSE aborts: no mstatus write, no jump.
      launch("abort", 32'h40, 1'b1, 1'b0, 1'b0, 32'h8, 32'h100);
      step();
      clear_events();
      step();
      check_eq("abort_in_mcause", {19'h0, bus.csr_we_o, bus.csr_waddr_o}, {19'h0, 1'b1, 12'h342});
      rst_n = 1'b0;
      step();
      check_quiet("abort_rst");
      rst_n = 1'b1;
      for (int i = 0; i < 4; i++) begin
         step();
         check_quiet($sformatf("abort_after%0d", i));
      end

      $display("test done: total=%0d bad=%0d", n_chk, n_bad);
      $finish;
   end

endmodule
